// File: rtl/clk_gate_pkg.sv
// rtl/clk_gate_pkg.sv - state encoding and defaults for the clock-gate enable controller
package clk_gate_pkg;

  // Encoding is visible on gate_state, so the values are fixed.
  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_WAKE  = 2'b01,
    ST_ON    = 2'b10,
    ST_DRAIN = 2'b11
  } gate_state_e;

  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_IDLE_CYCLES = 8;
  localparam int unsigned WAKE_CNT_W      = 16;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// rtl/clk_gate_ctrl_if.sv - activity/enable bundle between the gated domain and the gate controller (CLK_GATE_WAKE_CNT_EN adds wake_count)
interface clk_gate_ctrl_if
  import clk_gate_pkg::*;
();

  logic                  wake_req;
  logic                  busy;
  logic                  CLK_EN;
  logic                  clk_ready;
  logic [1:0]            gate_state;
`ifdef CLK_GATE_WAKE_CNT_EN
  logic [WAKE_CNT_W-1:0] wake_count;
`endif

  // Controller side: samples activity, drives the enable and status.
  modport slave (
    input  wake_req,
    input  busy,
    output CLK_EN,
    output clk_ready,
    output gate_state
`ifdef CLK_GATE_WAKE_CNT_EN
    ,
    output wake_count
`endif
  );

  // Requester side: drives activity, observes the enable and status.
  modport master (
    output wake_req,
    output busy,
    input  CLK_EN,
    input  clk_ready,
    input  gate_state
`ifdef CLK_GATE_WAKE_CNT_EN
    ,
    input  wake_count
`endif
  );

endinterface

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - enable-side FSM for CLK_GATE with settle and idle hysteresis (CLK_GATE_WAKE_CNT_EN adds a saturating wake counter)
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  clk_gate_ctrl_if.slave  bus
);

  // Terminal counts, truncated to the shared counter width.
  localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);

  gate_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clk_en_q;
  logic                 clk_ready_q;
  logic                 active;

  assign active = bus.wake_req | bus.busy;

  // Next state and shared counter; the counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (active) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Settle always completes, even if activity goes away meanwhile.
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (!active) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Re-activation takes priority over the terminal count.
        if (active) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and Moore outputs decoded from the next state so they are pure flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      clk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= (state_d != ST_OFF);
      clk_ready_q <= (state_d == ST_ON) || (state_d == ST_DRAIN);
    end
  end

  assign bus.CLK_EN     = clk_en_q;
  assign bus.clk_ready  = clk_ready_q;
  assign bus.gate_state = state_q;

`ifdef CLK_GATE_WAKE_CNT_EN
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;

  // Count only cold wake-ups (OFF->WAKE), saturating at all-ones.
  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if ((state_q == ST_OFF) && (state_d == ST_WAKE) && (wake_cnt_q != '1)) begin
      wake_cnt_d = wake_cnt_q + 1'b1;
    end
  end

  // Wake counter register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wake_cnt_q <= '0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign bus.wake_count = wake_cnt_q;
`endif

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Enable-side controller for the integrated clock-gating cell: it generates the CLK_EN input of CLK_GATE.
- Clock-domain activity is reported through wake_req and busy.
- The block opens the gate, waits a settle period, then acknowledges with clk_ready.
- After a programmable idle hysteresis it closes the gate again.
- Sits in the always-on (ungated) domain next to CLK_GATE; scan override remains at the gate cell, not here.

Parameters:
- WAKE_CYCLES, 2: cycles CLK_EN is high before clk_ready asserts; legal range >= 1.
- IDLE_CYCLES, 8: consecutive idle cycles in DRAIN before the gate closes; legal range >= 1.
- CNT_WIDTH, 4: shared counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES) - 1.

Ports:
- CLK  in  1  free-running ungated clock.
- RST  in  1  reset, synchronous, active-low.
- wake_req  in  1  request for the gated clock; level, held while the clock is needed.
- busy  in  1  gated-domain busy indication; keeps the clock alive.
- CLK_EN  out  1  enable to CLK_GATE; registered.
- clk_ready  out  1  gated clock running and settled; registered.
- gate_state  out  2  current FSM state: OFF=00, WAKE=01, ON=10, DRAIN=11.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RST is synchronous and active-low: at any rising edge with RST=0, state=OFF, cnt=0, CLK_EN=0, clk_ready=0, regardless of the current state (including mid-WAKE or mid-DRAIN).
- Outputs are registered and Moore-decoded from the next state:
  - CLK_EN=1 in WAKE, ON and DRAIN.
  - clk_ready=1 in ON and DRAIN.
- "active" means wake_req | busy, sampled at the rising edge.
- OFF:
  - active=1 -> WAKE, cnt=0; CLK_EN is high after that edge.
  - Otherwise stay in OFF.
- WAKE:
  - cnt increments each edge.
  - At the edge where cnt==WAKE_CYCLES-1 -> ON.
  - No abort: dropping active during WAKE still completes to ON.
  - Latency: active sampled at edge k gives CLK_EN=1 from edge k and clk_ready=1 from edge k+WAKE_CYCLES.
- ON:
  - active=0 -> DRAIN, cnt=0.
  - Otherwise stay in ON.
- DRAIN:
  - active=1 -> ON, cnt=0; clk_ready never drops on re-activation.
  - Otherwise cnt increments; at the edge where cnt==IDLE_CYCLES-1 -> OFF, with CLK_EN=0 and clk_ready=0 after that edge.
  - Idle sampled first at edge m gives CLK_EN low from edge m+IDLE_CYCLES.
- Counter:
  - Unsigned; never wraps, since it is cleared on every state entry.
  - Compare uses CNT_WIDTH-bit truncated constants.
- Simultaneous events:
  - RST=0 overrides everything.
  - In DRAIN at terminal count, active=1 wins (-> ON).
  - If only busy is high, it keeps the clock alive exactly as wake_req does.
- No glitch paths: CLK_EN is a flop output only; CLK_GATE latches it on CLK low.

Optional Feature:
- Macro: CLK_GATE_WAKE_CNT_EN.
- Defined:
  - Adds output wake_count[15:0], reset 0.
  - Increments on every OFF->WAKE transition and saturates at 16'hFFFF.
  - DRAIN->ON does not count.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clk_gate_pkg holds:
  - state encoding constants ST_OFF, ST_WAKE, ST_ON, ST_DRAIN (2-bit);
  - default WAKE_CYCLES and IDLE_CYCLES;
  - WAKE_CNT_W=16.
- No sub-module: FSM, shared counter and optional wake counter stay inline.
- Top-level integration instantiates clk_gate_ctrl alongside CLK_GATE.

Test Plan:
- Reset and OFF hold:
  - Stimulus: RST=0 for 3 edges, then release with wake_req=busy=0 for 20 cycles.
  - Required: CLK_EN=0, clk_ready=0, gate_state=00 throughout.
- Wake latency:
  - Stimulus: wake_req=1 sampled at edge 10 (defaults).
  - Required: CLK_EN=1 from edge 10, gate_state=01; clk_ready=1 and gate_state=10 from edge 12.
- Full drain:
  - Stimulus: from ON, drop wake_req at edge 20.
  - Required: gate_state=11 from edge 20; CLK_EN=0, clk_ready=0, gate_state=00 from edge 28.
- Re-activation in DRAIN:
  - Stimulus: from ON, idle at edge 20; busy=1 sampled at edge 27.
  - Required: gate_state=10 at edge 27; CLK_EN and clk_ready never drop; a subsequent idle needs a fresh 8 cycles.
- Reset mid-WAKE and WAKE non-abort:
  - Stimulus A: RST=0 at the first WAKE edge.
  - Required A: outputs return to 0 at that edge.
  - Stimulus B: separately, pulse wake_req for 1 cycle.
  - Required B: WAKE completes, ON lasts 1 cycle, then DRAIN runs 8 cycles to OFF.
- With CLK_GATE_WAKE_CNT_EN:
  - Stimulus: 3 OFF->WAKE cycles plus 1 DRAIN->ON.
  - Required: wake_count=3.
  - Stimulus: force wake_count to 16'hFFFF, then one more wake.
  - Required: wake_count stays 16'hFFFF.
